vend_change_dispenser: RTL and testbench

Downstream stage of the vending-machine controller: on a start pulse from the controller's dispense state, it computes change (paid − cost) and pays it out coin by coin to a three-tube coin hopper over a 4-phase req/ack handshake, largest denomination first. It skips empty tubes, detects a dead hopper by timeout, and reports completion or fault back to the controller and display path.

---
 rtl/vend_pkg.sv | 39 +++
 rtl/vend_change_dispenser.sv | 167 ++++++++++++++++
 tb/tb_vend_change_dispenser.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/vend_pkg.sv
// Shared types and constants for the vending change dispenser.
package vend_pkg;

    // Dispenser FSM states
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CALC,
        ST_SELECT,
        ST_REQ_HI,
        ST_REQ_LO,
        ST_DONE,
        ST_FAULT
    } state_t;

    // Hopper denomination select codes
    localparam logic [1:0] COIN_1  = 2'd0;
    localparam logic [1:0] COIN_5  = 2'd1;
    localparam logic [1:0] COIN_10 = 2'd2;

    // Denomination values
    localparam int unsigned VAL_1  = 1;
    localparam int unsigned VAL_5  = 5;
    localparam int unsigned VAL_10 = 10;

    // Bit positions of each tube in the empty flag vector {10,5,1}
    localparam int unsigned EMPTY_IDX_1  = 0;
    localparam int unsigned EMPTY_IDX_5  = 1;
    localparam int unsigned EMPTY_IDX_10 = 2;

    // Value of the coin behind a select code
    function automatic int unsigned coin_value(input logic [1:0] sel);
        case (sel)
            COIN_10: coin_value = VAL_10;
            COIN_5:  coin_value = VAL_5;
            default: coin_value = VAL_1;
        endcase
    endfunction

endpackage

// File: rtl/vend_change_dispenser.sv
// Computes change and pays it out largest coin first over a 4-phase hopper handshake.
module vend_change_dispenser
    import vend_pkg::*;
#(
    parameter int unsigned AMT_W       = 8,
    parameter int unsigned ACK_TIMEOUT = 1000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AMT_W-1:0] paid,
    input  logic [AMT_W-1:0] cost,
    input  logic [2:0]       empty,
    output logic             coin_req,
    output logic [1:0]       coin_sel,
    input  logic             coin_ack,
    output logic             busy,
    output logic             done,
    output logic             fault,
    output logic [AMT_W-1:0] dispensed,
    output logic [AMT_W-1:0] remaining
);

    localparam int unsigned        CNT_W    = $clog2(ACK_TIMEOUT + 1);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(ACK_TIMEOUT - 1);

    state_t           state,       state_nxt;
    logic [AMT_W-1:0] paid_q,      paid_nxt;
    logic [AMT_W-1:0] cost_q,      cost_nxt;
    logic [CNT_W-1:0] tmo_cnt,     tmo_cnt_nxt;
    logic             coin_req_nxt;
    logic [1:0]       coin_sel_nxt;
    logic             busy_nxt;
    logic             done_nxt;
    logic             fault_nxt;
    logic [AMT_W-1:0] dispensed_nxt;
    logic [AMT_W-1:0] remaining_nxt;
    logic [AMT_W-1:0] coin_amt;

    // Value of the coin currently in flight
    assign coin_amt = AMT_W'(coin_value(coin_sel));

    // State and registered outputs; reset drops coin_req immediately
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            paid_q    <= '0;
            cost_q    <= '0;
            tmo_cnt   <= '0;
            coin_req  <= 1'b0;
            coin_sel  <= COIN_1;
            busy      <= 1'b0;
            done      <= 1'b0;
            fault     <= 1'b0;
            dispensed <= '0;
            remaining <= '0;
        end else begin
            state     <= state_nxt;
            paid_q    <= paid_nxt;
            cost_q    <= cost_nxt;
            tmo_cnt   <= tmo_cnt_nxt;
            coin_req  <= coin_req_nxt;
            coin_sel  <= coin_sel_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            fault     <= fault_nxt;
            dispensed <= dispensed_nxt;
            remaining <= remaining_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt     = state;
        paid_nxt      = paid_q;
        cost_nxt      = cost_q;
        tmo_cnt_nxt   = tmo_cnt;
        coin_req_nxt  = coin_req;
        coin_sel_nxt  = coin_sel;
        fault_nxt     = fault;
        dispensed_nxt = dispensed;
        remaining_nxt = remaining;

        case (state)
            ST_IDLE: begin
                if (start) begin
                    paid_nxt      = paid;
                    cost_nxt      = cost;
                    fault_nxt     = 1'b0;
                    dispensed_nxt = '0;
                    state_nxt     = ST_CALC;
                end
            end

            ST_CALC: begin
                if (paid_q < cost_q) begin
                    fault_nxt     = 1'b1;
                    remaining_nxt = '0;
                    state_nxt     = ST_FAULT;
                end else begin
                    remaining_nxt = paid_q - cost_q;
                    state_nxt     = ST_SELECT;
                end
            end

            ST_SELECT: begin
                // Largest non-empty denomination that still fits the remainder
                if (remaining == '0) begin
                    state_nxt = ST_DONE;
                end else if (!empty[EMPTY_IDX_10] && remaining >= AMT_W'(VAL_10)) begin
                    coin_sel_nxt = COIN_10;
                    coin_req_nxt = 1'b1;
                    tmo_cnt_nxt  = '0;
                    state_nxt    = ST_REQ_HI;
                end else if (!empty[EMPTY_IDX_5] && remaining >= AMT_W'(VAL_5)) begin
                    coin_sel_nxt = COIN_5;
                    coin_req_nxt = 1'b1;
                    tmo_cnt_nxt  = '0;
                    state_nxt    = ST_REQ_HI;
                end else if (!empty[EMPTY_IDX_1]) begin
                    coin_sel_nxt = COIN_1;
                    coin_req_nxt = 1'b1;
                    tmo_cnt_nxt  = '0;
                    state_nxt    = ST_REQ_HI;
                end else begin
                    fault_nxt = 1'b1;
                    state_nxt = ST_FAULT;
                end
            end

            ST_REQ_HI: begin
                if (coin_ack) begin
                    coin_req_nxt = 1'b0;
                    tmo_cnt_nxt  = '0;
                    state_nxt    = ST_REQ_LO;
                end else if (tmo_cnt == CNT_LAST) begin
                    coin_req_nxt = 1'b0;
                    fault_nxt    = 1'b1;
                    state_nxt    = ST_FAULT;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
                end
            end

            ST_REQ_LO: begin
                if (!coin_ack) begin
                    remaining_nxt = remaining - coin_amt;
                    dispensed_nxt = dispensed + coin_amt;
                    state_nxt     = ST_SELECT;
                end else if (tmo_cnt == CNT_LAST) begin
                    fault_nxt = 1'b1;
                    state_nxt = ST_FAULT;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + CNT_W'(1);
                end
            end

            ST_DONE:  state_nxt = ST_IDLE;
            ST_FAULT: state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase

        busy_nxt = (state_nxt != ST_IDLE);
        done_nxt = (state_nxt == ST_DONE);
    end

endmodule

// File: tb/tb_vend_change_dispenser.sv
// Self-checking bench: directed and random transactions against a greedy change model.
module tb_vend_change_dispenser;

    localparam int unsigned TMO = 24;

    logic       clk;
    logic       reset;
    logic       start;
    logic [7:0] paid;
    logic [7:0] cost;
    logic [2:0] empty;
    logic       coin_req;
    logic [1:0] coin_sel;
    logic       coin_ack;
    logic       busy;
    logic       done;
    logic       fault;
    logic [7:0] dispensed;
    logic [7:0] remaining;

    int  errors = 0;
    int  checks = 0;
    int  got[$];
    int  exp_coins[$];
    bit  hopper_dead = 0;
    bit  hopper_busy = 0;
    int  sel_unstable = 0;

    vend_change_dispenser #(.AMT_W(8), .ACK_TIMEOUT(TMO)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .paid      (paid),
        .cost      (cost),
        .empty     (empty),
        .coin_req  (coin_req),
        .coin_sel  (coin_sel),
        .coin_ack  (coin_ack),
        .busy      (busy),
        .done      (done),
        .fault     (fault),
        .dispensed (dispensed),
        .remaining (remaining)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int denom(input logic [1:0] s);
        case (s)
            2'd0:    denom = 1;
            2'd1:    denom = 5;
            2'd2:    denom = 10;
            default: denom = 0;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // Hopper: acks each request after a random delay, records the coin it paid
    initial begin
        coin_ack = 1'b0;
        forever begin
            @(negedge clk);
            if (coin_req === 1'b1 && !coin_ack && !hopper_dead) begin
                logic [1:0] s;
                hopper_busy = 1;
                s = coin_sel;
                repeat ($urandom_range(0, 3)) begin
                    @(negedge clk);
                    if (coin_req === 1'b1 && coin_sel !== s) sel_unstable++;
                end
                coin_ack = 1'b1;
                got.push_back(denom(s));
                for (int k = 0; k < 50 && coin_req === 1'b1; k++) @(negedge clk);
                repeat ($urandom_range(0, 3)) @(negedge clk);
                coin_ack = 1'b0;
                hopper_busy = 0;
            end
        end
    end

    // Greedy change model: coin list, final fault, remainder and total paid
    task automatic build_model(input int p, input int c, input logic [2:0] e,
                               output bit f, output int rem, output int disp);
        int d;
        exp_coins.delete();
        f = 0;
        disp = 0;
        if (p < c) begin
            f = 1;
            rem = 0;
            return;
        end
        rem = p - c;
        while (rem > 0) begin
            d = 0;
            if (!e[2] && rem >= 10)     d = 10;
            else if (!e[1] && rem >= 5) d = 5;
            else if (!e[0])             d = 1;
            if (d == 0) begin
                f = 1;
                break;
            end
            exp_coins.push_back(d);
            rem -= d;
            disp += d;
        end
    endtask

    task automatic run_txn(input int p, input int c, input logic [2:0] e, input bit dead);
        bit exp_f;
        int exp_rem, exp_disp, base, cyc, done_cnt, done_cyc, first_req, req_cyc, inv_bad, n;
        build_model(p, c, e, exp_f, exp_rem, exp_disp);
        if (dead && exp_coins.size() > 0) begin
            exp_f = 1;
            exp_rem = p - c;
            exp_disp = 0;
            exp_coins.delete();
        end
        hopper_dead = dead;
        paid  = 8'(p);
        cost  = 8'(c);
        empty = e;
        base  = got.size();
        done_cnt = 0; done_cyc = -1; first_req = -1; req_cyc = 0; inv_bad = 0;

        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        paid  = 8'($urandom);
        cost  = 8'($urandom);
        cyc   = 1;
        check("busy_c1", 32'(busy), 32'd1);
        check("fault_clr_c1", 32'(fault), 32'd0);
        check("disp_clr_c1", 32'(dispensed), 32'd0);

        while (busy === 1'b1 && cyc < 3000) begin
            start = (cyc == 2);
            if (done === 1'b1) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (coin_req === 1'b1) begin
                req_cyc++;
                if (first_req < 0) first_req = cyc;
            end
            if (cyc >= 2 && p >= c && (int'(remaining) + int'(dispensed)) != (p - c)) inv_bad++;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;

        check("no_hang", 32'(busy), 32'd0);
        check("done_count", 32'(done_cnt), exp_f ? 32'd0 : 32'd1);
        check("fault", 32'(fault), 32'(exp_f));
        check("remaining", 32'(remaining), 32'(exp_rem));
        check("dispensed", 32'(dispensed), 32'(exp_disp));
        check("invariant", 32'(inv_bad), 32'd0);
        n = got.size() - base;
        check("coin_count", 32'(n), 32'(exp_coins.size()));
        if (n == exp_coins.size())
            for (int i = 0; i < n; i++) check("coin_value", 32'(got[base + i]), 32'(exp_coins[i]));
        if (p < c) begin
            check("underpay_end_cyc", 32'(cyc), 32'd3);
            check("underpay_no_req", 32'(req_cyc), 32'd0);
        end else if (p == c) begin
            check("zero_done_cyc", 32'(done_cyc), 32'd3);
            check("zero_no_req", 32'(req_cyc), 32'd0);
        end else if (dead && !exp_f == 0 && exp_disp == 0 && exp_rem == p - c && req_cyc > 0) begin
            check("timeout_req_cycles", 32'(req_cyc), 32'(TMO));
        end
        if (req_cyc > 0) check("first_req_cyc", 32'(first_req), 32'd3);
        else if (p >= c) check("no_req_when_no_coin", 32'(exp_disp), 32'd0);
        hopper_dead = 0;
        @(negedge clk);
    endtask

    initial begin
        int rises;
        bit prev;
        reset = 1'b1;
        start = 1'b0;
        paid  = '0;
        cost  = '0;
        empty = '0;
        repeat (3) @(negedge clk);
        check("rst_coin_req", 32'(coin_req), 32'd0);
        check("rst_coin_sel", 32'(coin_sel), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_fault", 32'(fault), 32'd0);
        check("rst_dispensed", 32'(dispensed), 32'd0);
        check("rst_remaining", 32'(remaining), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        run_txn(20, 6, 3'b000, 0);
        run_txn(16, 5, 3'b100, 0);
        run_txn(3, 6, 3'b000, 0);
        run_txn(6, 6, 3'b000, 0);
        run_txn(9, 0, 3'b011, 0);
        run_txn(15, 0, 3'b000, 1);

        // Reset while the second coin request is outstanding
        paid  = 8'd30;
        cost  = 8'd5;
        empty = 3'b000;
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        rises = 0;
        prev  = 0;
        for (int k = 0; k < 500 && rises < 2; k++) begin
            @(negedge clk);
            if (coin_req === 1'b1 && !prev) rises++;
            prev = coin_req;
        end
        check("rst_wait_second_req", 32'(rises), 32'd2);
        #2 reset = 1'b1;
        #1;
        check("async_coin_req", 32'(coin_req), 32'd0);
        check("async_busy", 32'(busy), 32'd0);
        check("async_fault", 32'(fault), 32'd0);
        check("async_done", 32'(done), 32'd0);
        check("async_coin_sel", 32'(coin_sel), 32'd0);
        check("async_dispensed", 32'(dispensed), 32'd0);
        check("async_remaining", 32'(remaining), 32'd0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 100 && (hopper_busy || coin_ack); k++) @(negedge clk);
        check("hopper_idle", 32'(coin_ack), 32'd0);
        run_txn(30, 5, 3'b000, 0);

        // Random transactions
        for (int t = 0; t < 16; t++) begin
            int p, c;
            p = $urandom_range(0, 60);
            c = ($urandom_range(0, 7) == 0) ? $urandom_range(0, 70) : $urandom_range(0, p);
            run_txn(p, c, 3'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0));
        end

        check("sel_stable", 32'(sel_unstable), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
